// File: rtl/bitonic_sort8_pipe_if.sv
// rtl/bitonic_sort8_pipe_if.sv - input/output vector handshake bundle for the bitonic sorter
interface bitonic_sort8_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] number_in1, number_in2, number_in3, number_in4;
  logic [WIDTH-1:0] number_in5, number_in6, number_in7, number_in8;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [WIDTH-1:0] number_out1, number_out2, number_out3, number_out4;
  logic [WIDTH-1:0] number_out5, number_out6, number_out7, number_out8;

  modport slave (
    input  in_valid, mode, out_ready,
    input  number_in1, number_in2, number_in3, number_in4,
    input  number_in5, number_in6, number_in7, number_in8,
    output in_ready, out_valid, out_mode,
    output number_out1, number_out2, number_out3, number_out4,
    output number_out5, number_out6, number_out7, number_out8
  );

  modport master (
    output in_valid, mode, out_ready,
    output number_in1, number_in2, number_in3, number_in4,
    output number_in5, number_in6, number_in7, number_in8,
    input  in_ready, out_valid, out_mode,
    input  number_out1, number_out2, number_out3, number_out4,
    input  number_out5, number_out6, number_out7, number_out8
  );
endinterface

// File: rtl/bitonic_sort8_pipe.sv
// rtl/bitonic_sort8_pipe.sv - six-stage pipelined 8-input bitonic sorter
// Each stage is one compare-exchange layer plus a register; a single stall signal freezes every stage.
module bitonic_sort8_pipe #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  bitonic_sort8_pipe_if.slave bus
);
  typedef logic [WIDTH-1:0] elem_t;

  elem_t in_vec [8];
  elem_t q      [1:6][8];
  elem_t nx     [1:6][8];
  logic  q_v    [1:6];
  logic  q_m    [1:6];
  logic  stall;

  function automatic logic gt(input elem_t a, input elem_t b);
    if (SIGNED) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign in_vec = '{bus.number_in1, bus.number_in2, bus.number_in3, bus.number_in4,
                    bus.number_in5, bus.number_in6, bus.number_in7, bus.number_in8};

  // D is the pair distance, B the size of the block whose sort direction is shared.
  for (genvar s = 1; s <= 6; s++) begin : g_stage
    localparam int D = (s == 4) ? 4 : ((s == 2 || s == 5) ? 2 : 1);
    localparam int B = (s == 1) ? 2 : ((s <= 3) ? 4 : 8);
    elem_t src [8];
    logic  src_m;
    if (s == 1) begin : g_first
      assign src   = in_vec;
      assign src_m = bus.mode;
    end else begin : g_next
      assign src   = q[s-1];
      assign src_m = q_m[s-1];
    end
    for (genvar i = 0; i < 8; i++) begin : g_lane
      localparam int P     = i ^ D;
      localparam bit LOWER = (i & D) == 0;
      localparam bit UP    = (i & B) == 0;
      elem_t lo, hi;
      logic  up, swap;
      assign lo   = LOWER ? src[i] : src[P];
      assign hi   = LOWER ? src[P] : src[i];
      assign up   = UP ^ src_m;
      // strict compare so equal elements never swap
      assign swap = up ? gt(lo, hi) : gt(hi, lo);
      assign nx[s][i] = (LOWER ^ swap) ? lo : hi;
    end
  end

  assign stall        = q_v[6] && !bus.out_ready;
  assign bus.in_ready = !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 1; s <= 6; s++) begin
        q_v[s] <= 1'b0;
        q_m[s] <= 1'b0;
        for (int i = 0; i < 8; i++) q[s][i] <= '0;
      end
    end else if (!stall) begin
      q_v[1] <= bus.in_valid;
      q_m[1] <= bus.mode;
      for (int s = 2; s <= 6; s++) begin
        q_v[s] <= q_v[s-1];
        q_m[s] <= q_m[s-1];
      end
      for (int s = 1; s <= 6; s++) q[s] <= nx[s];
    end
  end

  assign bus.out_valid   = q_v[6];
  assign bus.out_mode    = q_m[6];
  assign bus.number_out1 = q[6][0];
  assign bus.number_out2 = q[6][1];
  assign bus.number_out3 = q[6][2];
  assign bus.number_out4 = q[6][3];
  assign bus.number_out5 = q[6][4];
  assign bus.number_out6 = q[6][5];
  assign bus.number_out7 = q[6][6];
  assign bus.number_out8 = q[6][7];
endmodule

// File: tb/tb_bitonic_sort8_pipe.sv
// tb/tb_bitonic_sort8_pipe.sv - scoreboard bench for the pipelined bitonic sorter
module tb_bitonic_sort8_pipe;
  typedef logic [7:0][7:0] vec_t;
  typedef struct {
    vec_t v;
    logic m;
    int   t;
    bit   lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   out_cnt = 0;
  exp_t sb[$];
  exp_t sbs[$];
  int   pop_t[$];
  vec_t tv_in  [8];
  vec_t tv_asc [8];

  bitonic_sort8_pipe_if #(.WIDTH(8)) bus_u ();
  bitonic_sort8_pipe_if #(.WIDTH(8)) bus_s ();

  bitonic_sort8_pipe #(.WIDTH(8), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u.slave));
  bitonic_sort8_pipe #(.WIDTH(8), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [7:0] a, b, c, d, e, f, g, h);
    vec_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    r[4] = e; r[5] = f; r[6] = g; r[7] = h;
    return r;
  endfunction

  function automatic vec_t rev(input vec_t x);
    vec_t r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic vec_t outs_u();
    return {bus_u.number_out8, bus_u.number_out7, bus_u.number_out6, bus_u.number_out5,
            bus_u.number_out4, bus_u.number_out3, bus_u.number_out2, bus_u.number_out1};
  endfunction

  function automatic vec_t outs_s();
    return {bus_s.number_out8, bus_s.number_out7, bus_s.number_out6, bus_s.number_out5,
            bus_s.number_out4, bus_s.number_out3, bus_s.number_out2, bus_s.number_out1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive_u(input vec_t v, input logic m);
    bus_u.mode = m;
    bus_u.number_in1 = v[0]; bus_u.number_in2 = v[1]; bus_u.number_in3 = v[2]; bus_u.number_in4 = v[3];
    bus_u.number_in5 = v[4]; bus_u.number_in6 = v[5]; bus_u.number_in7 = v[6]; bus_u.number_in8 = v[7];
  endtask

  task automatic drive_s(input vec_t v, input logic m);
    bus_s.mode = m;
    bus_s.number_in1 = v[0]; bus_s.number_in2 = v[1]; bus_s.number_in3 = v[2]; bus_s.number_in4 = v[3];
    bus_s.number_in5 = v[4]; bus_s.number_in6 = v[5]; bus_s.number_in7 = v[6]; bus_s.number_in8 = v[7];
  endtask

  // Called at a falling edge; returns at the falling edge after the vector is taken.
  task automatic send(input vec_t v, input vec_t asc, input logic m, input bit lat);
    exp_t e;
    int   guard = 0;
    drive_u(v, m);
    bus_u.in_valid = 1'b1;
    forever begin
      #1;
      if (bus_u.in_ready) break;
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        check("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    e.v = m ? rev(asc) : asc;
    e.m = m;
    e.t = cyc;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    bus_u.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_u.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin : mon_u
    vec_t held;
    logic held_m;
    bit   stl;
    exp_t e;
    stl = 1'b0;
    held = '0;
    held_m = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (bus_u.out_valid) begin
        if (stl) begin
          check("stall_data_stable", outs_u(), held);
          check("stall_mode_stable", {63'd0, bus_u.out_mode}, {63'd0, held_m});
        end
        if (!bus_u.out_ready) begin
          check("stall_in_ready", {63'd0, bus_u.in_ready}, 64'd0);
          held = outs_u();
          held_m = bus_u.out_mode;
          stl = 1'b1;
        end else begin
          stl = 1'b0;
          out_cnt++;
          pop_t.push_back(cyc);
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h, expected no output", outs_u());
          end else begin
            e = sb.pop_front();
            check("sorted_data", outs_u(), e.v);
            check("out_mode", {63'd0, bus_u.out_mode}, {63'd0, e.m});
            if (e.lat) check("latency", 64'(cyc - e.t), 64'd6);
          end
        end
      end else begin
        stl = 1'b0;
      end
    end
  end

  initial begin : mon_s
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus_s.out_valid) begin
        if (sbs.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL signed_unexpected_output: got %h, expected no output", outs_s());
        end else begin
          e = sbs.pop_front();
          check("signed_data", outs_s(), e.v);
          check("signed_latency", 64'(cyc - e.t), 64'd6);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : stim
    exp_t es;
    int   cnt0;
    tv_in[0] = mk(5, 3, 8, 1, 9, 2, 7, 4);          tv_asc[0] = mk(1, 2, 3, 4, 5, 7, 8, 9);
    tv_in[1] = mk(4, 4, 0, 255, 7, 7, 1, 0);        tv_asc[1] = mk(0, 0, 1, 4, 4, 7, 7, 255);
    tv_in[2] = mk(10, 20, 30, 40, 50, 60, 70, 80);  tv_asc[2] = mk(10, 20, 30, 40, 50, 60, 70, 80);
    tv_in[3] = mk(80, 70, 60, 50, 40, 30, 20, 10);  tv_asc[3] = mk(10, 20, 30, 40, 50, 60, 70, 80);
    tv_in[4] = mk(8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h10, 8'hF0);
    tv_asc[4] = mk(8'h00, 8'h01, 8'h10, 8'h7F, 8'h80, 8'hF0, 8'hFE, 8'hFF);
    tv_in[5] = mk(200, 17, 17, 99, 0, 255, 128, 3); tv_asc[5] = mk(0, 3, 17, 17, 99, 128, 200, 255);
    tv_in[6] = mk(42, 42, 42, 42, 42, 42, 42, 42);  tv_asc[6] = mk(42, 42, 42, 42, 42, 42, 42, 42);
    tv_in[7] = mk(1, 0, 1, 0, 1, 0, 1, 0);          tv_asc[7] = mk(0, 0, 0, 0, 1, 1, 1, 1);

    bus_u.in_valid = 1'b0; bus_u.out_ready = 1'b1; drive_u('0, 1'b0);
    bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b1; drive_s('0, 1'b0);

    #1;
    check("reset_out_valid", {63'd0, bus_u.out_valid}, 64'd0);
    check("reset_data", outs_u(), 64'd0);
    check("reset_out_mode", {63'd0, bus_u.out_mode}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", {63'd0, bus_u.in_ready}, 64'd1);
    @(negedge clk);

    send(tv_in[0], tv_asc[0], 1'b0, 1'b1);
    idle(8);
    send(tv_in[1], tv_asc[1], 1'b1, 1'b1);
    idle(8);

    drive_s(tv_in[4], 1'b0);
    bus_s.in_valid = 1'b1;
    es.v = mk(8'h80, 8'hF0, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h7F);
    es.m = 1'b0;
    es.t = cyc;
    es.lat = 1'b1;
    sbs.push_back(es);
    send(tv_in[4], tv_asc[4], 1'b0, 1'b1);
    bus_s.in_valid = 1'b0;
    idle(8);

    for (int k = 0; k < 10; k++) send(tv_in[k % 8], tv_asc[k % 8], (k % 2) == 1, 1'b1);
    idle(10);

    pop_t.delete();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          if (k == 4) idle(1);
          send(tv_in[7-k], tv_asc[7-k], (k % 2) == 1, 1'b0);
        end
      end
      begin
        int g = 0;
        while (!bus_u.out_valid && g < 50) begin
          @(negedge clk);
          g++;
        end
        check("stall_trigger_timeout", {63'd0, g >= 50}, 64'd0);
        bus_u.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus_u.out_ready = 1'b1;
      end
    join
    idle(15);
    check("backpressure_count", 64'(pop_t.size()), 64'd8);
    if (pop_t.size() == 8) check("bubble_slot", 64'(pop_t[4] - pop_t[3]), 64'd2);

    for (int k = 0; k < 3; k++) send(tv_in[k + 5], tv_asc[k + 5], 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {63'd0, bus_u.out_valid}, 64'd0);
    check("async_reset_data", outs_u(), 64'd0);
    check("async_reset_out_mode", {63'd0, bus_u.out_mode}, 64'd0);
    sb.delete();
    sbs.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cnt0 = out_cnt;
    idle(12);
    check("no_output_after_reset", 64'(out_cnt - cnt0), 64'd0);
    send(tv_in[3], tv_asc[3], 1'b1, 1'b1);
    idle(10);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("signed_scoreboard_drained", 64'(sbs.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
